// File: rtl/whack_a_mole_game_if.sv
// Player-facing signal bundle for the whack-a-mole game controller.
// The master side drives the buttons and start; the slave side is the game core.
interface whack_a_mole_game_if;
    logic       start;
    logic [3:0] btn;
    logic [1:0] mole_index;
    logic       mole_active;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;
    logic       hit;
    logic       miss;

    modport master (
        output start, btn,
        input  mole_index, mole_active, score, misses, game_over, hit, miss
    );

    modport slave (
        input  start, btn,
        output mole_index, mole_active, score, misses, game_over, hit, miss
    );
endinterface

// File: rtl/whack_a_mole_game.sv
// Game-control core: picks a pseudo-random mole, times the hit window,
// scores button edges against it and ends the game after MAX_MISSES misses.
module whack_a_mole_game #(
    parameter int unsigned MOLE_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 5_000_000,
    parameter int unsigned MAX_MISSES = 3
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    whack_a_mole_game_if.slave game_if
);
    localparam int unsigned MAX_TICKS = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] MOLE_LAST  = CNT_W'(MOLE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);
    localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISSES);
    localparam logic [15:0]      LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SHOW, ST_OVER} state_e;

    state_e           state_q, state_d;
    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       sync2_q, sync2_d;
    logic [4:0]       prev_q, prev_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mole_index_q, mole_index_d;
    logic             mole_active_q, mole_active_d;
    logic [7:0]       score_q, score_d;
    logic [3:0]       misses_q, misses_d;
    logic             game_over_q, game_over_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;

    logic [4:0] rise;
    logic       start_edge;
    logic [3:0] btn_edge;
    logic       wrong_ev, right_ev, timeout_ev;
    logic       show_miss, show_hit;
    logic [3:0] misses_inc;
    logic [1:0] cand, next_pos;

    // Bit 4 carries start, bits 3:0 the buttons; only rising edges matter.
    assign rise       = sync2_q & ~prev_q;
    assign start_edge = rise[4];
    assign btn_edge   = rise[3:0];

    // A wrong button always wins, even if the right one edges in the same cycle.
    assign wrong_ev   = |(btn_edge & ~(4'b0001 << mole_index_q));
    assign right_ev   = btn_edge[mole_index_q];
    assign timeout_ev = (cnt_q == MOLE_LAST);
    assign show_miss  = wrong_ev | (~right_ev & timeout_ev);
    assign show_hit   = ~wrong_ev & right_ev;
    assign misses_inc = misses_q + 4'd1;

    assign cand     = lfsr_q[1:0];
    assign next_pos = (cand == mole_index_q) ? cand + 2'd1 : cand;

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_edge) state_d = ST_GAP;
            ST_GAP:  if (cnt_q == GAP_LAST) state_d = ST_SHOW;
            ST_SHOW: begin
                if (show_miss) begin
                    state_d = (misses_inc == MISS_LIMIT) ? ST_OVER : ST_GAP;
                end else if (show_hit) begin
                    state_d = ST_GAP;
                end
            end
            ST_OVER: if (start_edge) state_d = ST_GAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        sync1_d      = {game_if.start, game_if.btn};
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cnt_d        = cnt_q + CNT_W'(1);
        mole_index_d = mole_index_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                cnt_d = '0;
                if (start_edge) begin
                    score_d  = '0;
                    misses_d = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    mole_index_d = next_pos;
                    cnt_d        = '0;
                end
            end
            ST_SHOW: begin
                if (show_miss) begin
                    misses_d = misses_inc;
                    miss_d   = 1'b1;
                    cnt_d    = '0;
                end else if (show_hit) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    hit_d = 1'b1;
                    cnt_d = '0;
                end
            end
            default: cnt_d = '0;
        endcase

        mole_active_d = (state_d == ST_SHOW);
        game_over_d   = (state_d == ST_OVER);
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            lfsr_q        <= LFSR_SEED;
            cnt_q         <= '0;
            mole_index_q  <= '0;
            mole_active_q <= 1'b0;
            score_q       <= '0;
            misses_q      <= '0;
            game_over_q   <= 1'b0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            mole_index_q  <= mole_index_d;
            mole_active_q <= mole_active_d;
            score_q       <= score_d;
            misses_q      <= misses_d;
            game_over_q   <= game_over_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
        end
    end

    assign game_if.mole_index  = mole_index_q;
    assign game_if.mole_active = mole_active_q;
    assign game_if.score       = score_q;
    assign game_if.misses      = misses_q;
    assign game_if.game_over   = game_over_q;
    assign game_if.hit         = hit_q;
    assign game_if.miss        = miss_q;
endmodule

// File: tb/tb_whack_a_mole_game.sv
// Self-checking bench for whack_a_mole_game: scoreboard of expected hit/miss
// events plus an LFSR reference model that predicts every new mole position.
module tb_whack_a_mole_game;
    localparam int MOLE_TICKS = 20;
    localparam int GAP_TICKS  = 5;
    localparam int MAX_MISSES = 3;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b1;

    whack_a_mole_game_if game_if();

    whack_a_mole_game #(
        .MOLE_TICKS(MOLE_TICKS),
        .GAP_TICKS (GAP_TICKS),
        .MAX_MISSES(MAX_MISSES)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .game_if (game_if)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic       is_hit;
        logic [7:0] score;
        logic [3:0] misses;
        logic       over;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_score;
    logic [3:0] exp_misses;
    logic       prev_active;
    logic [1:0] prev_idx;
    logic [15:0] lfsr_m, lfsr_prev;

    // Reference LFSR, x^16+x^14+x^13+x^11+1, seed ACE1; lfsr_prev is the value used at the last edge.
    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end
    end

    function automatic logic [17:0] get_outs();
        return {game_if.mole_index, game_if.mole_active, game_if.score, game_if.misses,
                game_if.game_over, game_if.hit, game_if.miss};
    endfunction

    task automatic push_hit();
        exp_t e;
        if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
        e.is_hit = 1'b1; e.score = exp_score; e.misses = exp_misses; e.over = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_miss();
        exp_t e;
        exp_misses = exp_misses + 4'd1;
        e.is_hit = 1'b0; e.score = exp_score; e.misses = exp_misses;
        e.over = (exp_misses == 4'(MAX_MISSES));
        exp_q.push_back(e);
    endtask

    // Runs at every falling edge: predicts new moles and pops the scoreboard on each pulse.
    task automatic observe();
        exp_t       e;
        logic [1:0] cand;
        if (game_if.mole_active && !prev_active) begin
            cand = lfsr_prev[1:0];
            if (cand == prev_idx) cand = cand + 2'd1;
            checks++;
            if (game_if.mole_index !== cand) begin
                errors++;
                $display("FAIL mole_position: got %0d expected %0d", game_if.mole_index, cand);
            end
            checks++;
            if (game_if.mole_index === prev_idx) begin
                errors++;
                $display("FAIL mole_repeat: got %0d expected anything but %0d", game_if.mole_index, prev_idx);
            end
        end
        if (game_if.hit || game_if.miss) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got hit=%0b miss=%0b expected no pulse", game_if.hit, game_if.miss);
            end else begin
                e = exp_q.pop_front();
                if ({game_if.hit, game_if.miss, game_if.score, game_if.misses, game_if.game_over} !==
                    {e.is_hit, ~e.is_hit, e.score, e.misses, e.over}) begin
                    errors++;
                    $display("FAIL event: got hit=%0b miss=%0b score=%0d misses=%0d over=%0b expected hit=%0b miss=%0b score=%0d misses=%0d over=%0b",
                             game_if.hit, game_if.miss, game_if.score, game_if.misses, game_if.game_over,
                             e.is_hit, ~e.is_hit, e.score, e.misses, e.over);
                end
            end
        end
        prev_active = game_if.mole_active;
        prev_idx    = game_if.mole_index;
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        observe();
    endtask

    task automatic wait_active();
        int n = 0;
        while (!game_if.mole_active && n < 60) begin tick(); n++; end
        checks++;
        if (!game_if.mole_active) begin
            errors++;
            $display("FAIL wait_active: got mole_active=0 expected 1 within 60 cycles");
        end
    endtask

    task automatic wait_inactive();
        int n = 0;
        while (game_if.mole_active && n < 60) begin tick(); n++; end
        checks++;
        if (game_if.mole_active) begin
            errors++;
            $display("FAIL wait_inactive: got mole_active=1 expected 0 within 60 cycles");
        end
    endtask

    task automatic press_start();
        game_if.start = 1'b1;
        tick();
        game_if.start = 1'b0;
        exp_score  = '0;
        exp_misses = '0;
    endtask

    task automatic hit_once();
        logic [1:0] idx = game_if.mole_index;
        push_hit();
        game_if.btn = 4'b0001 << idx;
        tick();
        game_if.btn = 4'b0000;
        wait_inactive();
    endtask

    // One full unanswered window: must stay open exactly MOLE_TICKS cycles, then miss.
    task automatic timeout_window();
        int n = 0;
        wait_active();
        push_miss();
        while (game_if.mole_active && n < 100) begin n++; tick(); end
        checks++;
        if (n != MOLE_TICKS) begin
            errors++;
            $display("FAIL window_length: got %0d expected %0d", n, MOLE_TICKS);
        end
        checks++;
        if (game_if.miss !== 1'b1) begin
            errors++;
            $display("FAIL timeout_miss: got %0b expected 1", game_if.miss);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) tick();
        checks++;
        if (get_outs() !== 18'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", get_outs());
        end
        resetn = 1'b1;
        repeat (3) tick();
        checks++;
        if (get_outs() !== 18'd0) begin
            errors++;
            $display("FAIL idle_hold: got %h expected 0", get_outs());
        end
        press_start();
        wait_active();
        repeat (4) tick();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (get_outs() !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", get_outs());
        end
        repeat (2) tick();
        resetn = 1'b1;
        // start sampled at edge k, acted on at k+2, window opens after k+2+GAP_TICKS: 8th falling edge.
        press_start();
        n = 1;
        while (!game_if.mole_active && n < 40) begin tick(); n++; end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL start_to_active: got %0d expected 8", n);
        end
    endtask

    task automatic test_hit();
        logic [1:0] idx = game_if.mole_index;
        push_hit();
        game_if.btn = 4'b0001 << idx;
        tick();
        game_if.btn = 4'b0000;
        repeat (2) tick();
        checks++;
        if ({game_if.hit, game_if.score, game_if.mole_active} !== {1'b1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL hit_latency: got hit=%0b score=%0d active=%0b expected hit=1 score=1 active=0",
                     game_if.hit, game_if.score, game_if.mole_active);
        end
        tick();
        checks++;
        if (game_if.hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_width: got %0b expected 0", game_if.hit);
        end
        wait_active();
        checks++;
        if (game_if.mole_index === idx) begin
            errors++;
            $display("FAIL next_mole: got %0d expected anything but %0d", game_if.mole_index, idx);
        end
    endtask

    task automatic test_wrong_buttons();
        logic [1:0] idx = game_if.mole_index;
        logic [1:0] w   = idx + 2'd1;
        push_miss();
        game_if.btn = 4'b0001 << w;
        tick();
        game_if.btn = 4'b0000;
        wait_inactive();
        checks++;
        if ({game_if.miss, game_if.misses, game_if.score} !== {1'b1, 4'd1, 8'd1}) begin
            errors++;
            $display("FAIL wrong_button: got miss=%0b misses=%0d score=%0d expected miss=1 misses=1 score=1",
                     game_if.miss, game_if.misses, game_if.score);
        end
        wait_active();
        idx = game_if.mole_index;
        w   = idx + 2'd3;
        push_miss();
        game_if.btn = (4'b0001 << idx) | (4'b0001 << w);
        tick();
        game_if.btn = 4'b0000;
        wait_inactive();
        checks++;
        if ({game_if.miss, game_if.hit, game_if.misses, game_if.score} !== {1'b1, 1'b0, 4'd2, 8'd1}) begin
            errors++;
            $display("FAIL simultaneous_buttons: got miss=%0b hit=%0b misses=%0d score=%0d expected miss=1 hit=0 misses=2 score=1",
                     game_if.miss, game_if.hit, game_if.misses, game_if.score);
        end
    endtask

    task automatic test_timeout_over();
        logic [17:0] held;
        timeout_window();
        tick();
        checks++;
        if ({game_if.game_over, game_if.mole_active, game_if.score, game_if.misses} !== {1'b1, 1'b0, 8'd1, 4'd3}) begin
            errors++;
            $display("FAIL game_over: got over=%0b active=%0b score=%0d misses=%0d expected over=1 active=0 score=1 misses=3",
                     game_if.game_over, game_if.mole_active, game_if.score, game_if.misses);
        end
        held = get_outs();
        for (int i = 0; i < 8; i++) begin
            game_if.btn = 4'($urandom_range(1, 15));
            tick();
            game_if.btn = 4'b0000;
            tick();
        end
        checks++;
        if (get_outs() !== held) begin
            errors++;
            $display("FAIL over_hold: got %h expected %h", get_outs(), held);
        end
    endtask

    task automatic test_hold_restart();
        logic [1:0] idx;
        int         n;
        press_start();
        repeat (2) tick();
        checks++;
        if ({game_if.score, game_if.misses, game_if.game_over} !== {8'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_clear: got score=%0d misses=%0d over=%0b expected 0 0 0",
                     game_if.score, game_if.misses, game_if.game_over);
        end
        wait_active();
        idx = game_if.mole_index;
        push_hit();
        game_if.btn = 4'b0001 << idx;
        repeat (14) tick();
        game_if.btn = 4'b0000;
        push_miss();
        wait_inactive();
        checks++;
        if ({game_if.score, game_if.misses} !== {8'd1, 4'd1}) begin
            errors++;
            $display("FAIL held_button: got score=%0d misses=%0d expected score=1 misses=1",
                     game_if.score, game_if.misses);
        end
        // Hit whose edge is processed on the timeout cycle: must score, not miss.
        wait_active();
        idx = game_if.mole_index;
        n = 0;
        repeat (17) begin tick(); n++; end
        push_hit();
        game_if.btn = 4'b0001 << idx;
        tick();
        n++;
        game_if.btn = 4'b0000;
        while (game_if.mole_active && n < 40) begin tick(); n++; end
        checks++;
        if ({n == MOLE_TICKS, game_if.hit, game_if.score} !== {1'b1, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL hit_on_timeout: got len=%0d hit=%0b score=%0d expected len=%0d hit=1 score=2",
                     n, game_if.hit, game_if.score, MOLE_TICKS);
        end
        timeout_window();
        timeout_window();
        checks++;
        if ({game_if.game_over, game_if.score} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL second_over: got over=%0b score=%0d expected over=1 score=2",
                     game_if.game_over, game_if.score);
        end
    endtask

    task automatic test_saturation();
        press_start();
        for (int i = 0; i < 260; i++) begin
            wait_active();
            hit_once();
        end
        tick();
        checks++;
        if ({game_if.score, game_if.misses} !== {8'd255, 4'd0}) begin
            errors++;
            $display("FAIL saturation: got score=%0d misses=%0d expected score=255 misses=0",
                     game_if.score, game_if.misses);
        end
    endtask

    initial begin
        game_if.start = 1'b0;
        game_if.btn   = 4'b0000;
        exp_score     = '0;
        exp_misses    = '0;
        prev_active   = 1'b0;
        prev_idx      = 2'd0;
        #1 resetn = 1'b0;
        test_reset();
        test_hit();
        test_wrong_buttons();
        test_timeout_over();
        test_hold_restart();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
